// File: rtl/cache_arbiter.sv
// cache_arbiter
//   Shares one next-level cache port between NREQ upper-level caches.
//   A round-robin pick in IDLE latches the winner's request. WAIT holds
//   that request on the next-level port until nl_valid arrives or the
//   wait counter reaches TIMEOUT. RESP then pulses done (and err on
//   timeout) for one cycle and moves the pointer past the winner.
//
// Ports
//   clock, reset         rising-edge clock, synchronous active-high reset
//   req, we              per-requester request level / writeback select
//   addr, wdata          per-requester line address / write line (slice i)
//   gnt                  one-hot owner, high in WAIT and RESP
//   done, err            one-cycle completion pulse / timeout flag
//   rdata                last line captured from the next level
//   nl_request, nl_we,
//   nl_addr, nl_d        next-level request, zero outside WAIT
//   nl_q, nl_valid       next-level read line / completion strobe
module cache_arbiter #(
  parameter int NREQ     = 2,
  parameter int ADDRBITS = 32,
  parameter int DATABITS = 512,
  parameter int TIMEOUT  = 255
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ*ADDRBITS-1:0] addr,
  input  logic [NREQ*DATABITS-1:0] wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic [DATABITS-1:0]      rdata,
  output logic                     err,
  output logic                     nl_request,
  output logic                     nl_we,
  output logic [ADDRBITS-1:0]      nl_addr,
  output logic [DATABITS-1:0]      nl_d,
  input  logic [DATABITS-1:0]      nl_q,
  input  logic                     nl_valid
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] own;
  logic [CW-1:0] cnt;

  // Flat buses viewed as per-requester packed arrays.
  logic [NREQ-1:0][ADDRBITS-1:0] addr_v;
  logic [NREQ-1:0][DATABITS-1:0] wdata_v;
  assign addr_v  = addr;
  assign wdata_v = wdata;

  // Round-robin pick: first asserted req at or above rr_ptr, wrapping.
  logic          any_req;
  logic [IW-1:0] win;
  int            cand;

  always_comb begin
    any_req = 1'b0;
    win     = '0;
    cand    = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        win     = IW'(cand);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      own        <= '0;
      cnt        <= '0;
      rdata      <= '0;
      gnt        <= '0;
      done       <= '0;
      err        <= 1'b0;
      nl_request <= 1'b0;
      nl_we      <= 1'b0;
      nl_addr    <= '0;
      nl_d       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= '0;
          err  <= 1'b0;
          if (any_req) begin
            // Latch straight into the port registers; later requester
            // activity cannot disturb the transaction.
            own        <= win;
            gnt        <= '0;
            gnt[win]   <= 1'b1;
            nl_request <= 1'b1;
            nl_we      <= we[win];
            nl_addr    <= addr_v[win];
            nl_d       <= wdata_v[win];
            cnt        <= '0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          // nl_valid is tested first so it beats a simultaneous timeout.
          if (nl_valid || cnt == CNT_MAX) begin
            if (nl_valid) rdata <= nl_q;
            err        <= ~nl_valid;
            done[own]  <= 1'b1;
            nl_request <= 1'b0;
            nl_we      <= 1'b0;
            nl_addr    <= '0;
            nl_d       <= '0;
            cnt        <= '0;
            state      <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          done  <= '0;
          err   <= 1'b0;
          gnt   <= '0;
          if (int'(own) == NREQ - 1) rr_ptr <= '0;
          else                       rr_ptr <= own + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;

  localparam int AW = 32;
  localparam int DW = 512;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [1:0]     req   = '0;
  logic [1:0]     we    = '0;
  logic [2*AW-1:0] addr = '0;
  logic [2*DW-1:0] wdata = '0;
  logic [1:0]     gnt, done;
  logic [DW-1:0]  rdata;
  logic           err, nl_request, nl_we;
  logic [AW-1:0]  nl_addr;
  logic [DW-1:0]  nl_d;
  logic [DW-1:0]  nl_q = '0;
  logic           nl_valid = 1'b0;

  cache_arbiter #(.NREQ(2), .ADDRBITS(AW), .DATABITS(DW), .TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .err(err),
    .nl_request(nl_request), .nl_we(nl_we), .nl_addr(nl_addr), .nl_d(nl_d),
    .nl_q(nl_q), .nl_valid(nl_valid));

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]    done;
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] last_rdata = '0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clock) begin
    if (done !== 2'b00) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got %b exp none", done);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_done", done, mon_e.done);
        chk("sb_err", err, mon_e.err);
        chk("sb_rdata", rdata, mon_e.rdata);
      end
    end
  end

  // Serve one transaction from IDLE. lat < 0 means nl_valid never comes.
  task automatic serve(input int idx, input logic ewe, input logic [AW-1:0] eaddr,
                       input logic [DW-1:0] ed, input int lat, input logic [DW-1:0] q,
                       input bit scramble, input bit drop);
    int n, wl;
    logic [1:0] g;
    g = 2'(1 << idx);
    n = 0;
    while (gnt === 2'b00 && n < 10) begin tick(); n++; end
    chk("enter_gnt", gnt, g);
    chk("enter_req", nl_request, 1'b1);
    chk("enter_addr", nl_addr, eaddr);
    chk("enter_we", nl_we, ewe);
    chk("enter_d", nl_d, ed);
    if (drop) req[idx] = 1'b0;
    if (scramble) begin
      addr[idx*AW +: AW]  = ~eaddr;
      wdata[idx*DW +: DW] = ~ed;
      we[idx]             = ~ewe;
    end
    if (lat >= 0) begin
      repeat (lat) begin
        tick();
        chk("hold_addr", nl_addr, eaddr);
        chk("hold_d", nl_d, ed);
        chk("hold_we", nl_we, ewe);
      end
      nl_valid = 1'b1;
      nl_q     = q;
      sb.push_back('{g, 1'b0, q});
      last_rdata = q;
      tick();
      chk("resp_done", done, g);
      chk("resp_err", err, 1'b0);
      chk("resp_nlreq", nl_request, 1'b0);
      chk("resp_gnt", gnt, g);
      // nl_valid during RESP must be ignored.
      nl_q = ~q;
      tick();
      nl_valid = 1'b0;
      chk("idle_gnt", gnt, 2'b00);
      chk("idle_rdata", rdata, q);
    end else begin
      sb.push_back('{g, 1'b1, last_rdata});
      wl = 1;
      n  = 0;
      while (nl_request === 1'b1 && n < 20) begin
        tick();
        n++;
        if (nl_request === 1'b1) wl++;
      end
      chk("timeout_wait_len", wl, 5);
      chk("timeout_done", done, g);
      chk("timeout_err", err, 1'b1);
      tick();
      chk("timeout_idle_gnt", gnt, 2'b00);
      chk("timeout_rdata", rdata, last_rdata);
    end
  endtask

  initial begin
    int n;
    // Reset state
    repeat (2) tick();
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_done", done, 2'b00);
    chk("rst_err", err, 1'b0);
    chk("rst_nlreq", nl_request, 1'b0);
    chk("rst_nladdr", nl_addr, '0);
    chk("rst_nld", nl_d, '0);
    chk("rst_rdata", rdata, '0);
    reset = 1'b0;
    tick();

    // Single read, minimum latency, req dropped after latch
    addr[0 +: AW] = 32'h1000;
    req = 2'b01;
    serve(0, 1'b0, 32'h1000, '0, 0, {64{8'hA5}}, 1'b0, 1'b1);

    // Writeback from requester 1, inputs scrambled after latch
    we = 2'b10;
    addr[AW +: AW]  = 32'h2000;
    wdata[DW +: DW] = {32{16'hDEAD}};
    req = 2'b10;
    serve(1, 1'b1, 32'h2000, {32{16'hDEAD}}, 2, {64{8'h11}}, 1'b1, 1'b1);

    // Contention: pointer is back at 0, grants alternate 0,1,0,1
    we    = 2'b00;
    addr  = {32'h2000, 32'h1000};
    wdata = {{16{32'h0000_2222}}, {16{32'h0000_1111}}};
    req   = 2'b11;
    serve(0, 1'b0, 32'h1000, {16{32'h0000_1111}}, 0, {64{8'h3C}}, 1'b0, 1'b0);
    serve(1, 1'b0, 32'h2000, {16{32'h0000_2222}}, 1, {64{8'h4B}}, 1'b0, 1'b0);
    serve(0, 1'b0, 32'h1000, {16{32'h0000_1111}}, 0, {64{8'h5A}}, 1'b0, 1'b0);
    serve(1, 1'b0, 32'h2000, {16{32'h0000_2222}}, 2, {64{8'h69}}, 1'b0, 1'b0);
    req = 2'b00;
    tick();

    // Timeout: no nl_valid, rdata keeps the last line
    addr[0 +: AW] = 32'h3000;
    req = 2'b01;
    serve(0, 1'b0, 32'h3000, {16{32'h0000_1111}}, -1, '0, 1'b0, 1'b1);

    // Race: nl_valid on the cycle the counter hits TIMEOUT
    req = 2'b01;
    serve(0, 1'b0, 32'h3000, {16{32'h0000_1111}}, 4, {64{8'h77}}, 1'b0, 1'b1);

    // Reset mid-WAIT on requester 1; afterwards requester 0 wins
    req = 2'b10;
    n = 0;
    while (gnt === 2'b00 && n < 10) begin tick(); n++; end
    chk("mid_gnt", gnt, 2'b10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req   = 2'b00;
    chk("mid_rst_gnt", gnt, 2'b00);
    chk("mid_rst_done", done, 2'b00);
    chk("mid_rst_nlreq", nl_request, 1'b0);
    chk("mid_rst_nladdr", nl_addr, '0);
    chk("mid_rst_nld", nl_d, '0);
    chk("mid_rst_rdata", rdata, '0);
    repeat (3) tick();
    chk("mid_no_done", done, 2'b00);
    addr = {32'h6000, 32'h5000};
    req  = 2'b11;
    serve(0, 1'b0, 32'h5000, {16{32'h0000_1111}}, 0, {64{8'h99}}, 1'b0, 1'b0);
    req = 2'b00;
    repeat (4) tick();
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter NREQ, default 2, SHALL set the number of requesters (upper-level caches) sharing one next-level cache port.
REQ-002 Parameter ADDRBITS, default 32, SHALL set the address width.
REQ-003 Parameter DATABITS, default 512, SHALL set the line data width (64 items x 8 bits).
REQ-004 Parameter TIMEOUT, default 255, SHALL set the maximum number of WAIT cycles before abort; counter width is $clog2(TIMEOUT+1).
REQ-005 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-006 Port: clock  in  1  rising-edge clock for all state.
REQ-007 Port: reset  in  1  synchronous, active-high reset.
REQ-008 Port: req  in  NREQ  per-requester transaction request, level.
REQ-009 Port: we  in  NREQ  per-requester write enable (1 = writeback line, 0 = line fill).
REQ-010 Port: addr  in  NREQ*ADDRBITS  per-requester line address; requester i occupies slice [i*ADDRBITS +: ADDRBITS].
REQ-011 Port: wdata  in  NREQ*DATABITS  per-requester write line; slice i as for addr.
REQ-012 Port: gnt  out  NREQ  one-hot grant, high for the whole owned transaction.
REQ-013 Port: done  out  NREQ  one-cycle completion pulse to the granted requester.
REQ-014 Port: rdata  out  DATABITS  line returned by the next level.
REQ-015 Port: err  out  1  timeout flag, pulses together with done.
REQ-016 Port: nl_request  out  1  request to next-level cache.
REQ-017 Port: nl_we  out  1  write enable to next level.
REQ-018 Port: nl_addr  out  ADDRBITS  address to next level.
REQ-019 Port: nl_d  out  DATABITS  write line to next level.
REQ-020 Port: nl_q  in  DATABITS  read line from next level.
REQ-021 Port: nl_valid  in  1  next level completion strobe.

Function
REQ-022 FSM states SHALL be IDLE, WAIT, RESP; all transitions on rising clock.
REQ-023 IDLE: if any req bit is high, select winner by round-robin, latch its index, we, addr, wdata, clear timeout counter, go to WAIT; else stay IDLE.
REQ-024 Round-robin: search starts at pointer p, ascending modulo NREQ; p = 0 after reset; after RESP for index k, p = (k+1) mod NREQ.
REQ-025 WAIT: nl_request = 1, nl_we/nl_addr/nl_d = latched values; counter increments each cycle.
REQ-026 WAIT with nl_valid = 1: capture nl_q into rdata, go to RESP with err = 0.
REQ-027 WAIT with counter == TIMEOUT and nl_valid = 0: go to RESP with err = 1, rdata unchanged.
REQ-028 nl_valid and timeout in same cycle: nl_valid SHALL win (no error).
REQ-029 RESP: done[idx] = 1 and err as determined for exactly one cycle; update p; go to IDLE.
REQ-030 gnt[idx] SHALL be high in WAIT and RESP, zero in IDLE.
REQ-031 Outside WAIT, nl_request, nl_we, nl_addr, nl_d SHALL be driven 0 (never tristated).
REQ-032 nl_valid outside WAIT SHALL be ignored.
REQ-033 Requester inputs changing or req dropping after latch SHALL NOT affect the transaction; it completes and pulses done.
REQ-034 rdata SHALL hold its value until the next successful capture.
REQ-035 Minimum latency: req seen in IDLE at cycle n, nl_valid at n+1 -> done at n+2; at least one IDLE cycle between transactions.

Reset
REQ-036 On reset = 1 at a clock edge: state = IDLE, p = 0, counter = 0, rdata = 0; gnt, done, err, nl_request, nl_we, nl_addr, nl_d all 0 next cycle.
REQ-037 Reset during WAIT or RESP SHALL abort the transaction with no done pulse.

Verification
REQ-038 Single read: req=01, we=0, addr0=0x1000, nl_valid one cycle after entering WAIT with nl_q=0xA5.. -> nl_addr=0x1000, gnt=01, done=01 one cycle, rdata=0xA5.., err=0.
REQ-039 Contention: req=11 held continuously -> grants alternate 01,10,01,10 with one IDLE cycle between; done pulses match.
REQ-040 Writeback: req=10, we=10, wdata1=0xDEAD.. -> nl_we=1, nl_d=0xDEAD.. throughout WAIT; done=10.
REQ-041 Timeout: TIMEOUT=4, nl_valid never asserted -> WAIT lasts 5 cycles, done and err pulse together, rdata unchanged, nl_request drops.
REQ-042 Timeout race: nl_valid asserted on the cycle counter == TIMEOUT -> err=0, rdata captured.
REQ-043 Reset mid-WAIT: assert reset for one cycle in WAIT -> no done, all outputs 0, next req served from requester 0.
